// File: rtl/fpnew_pkg.sv
// Slice of the FPnew package used by the result scoreboard: formats and their encodings.
package fpnew_pkg;

    localparam int unsigned NUM_FP_FORMATS = 6;
    localparam int unsigned FP_FORMAT_BITS = 3;

    typedef enum logic [FP_FORMAT_BITS-1:0] {
        FP32    = 'd0,
        FP64    = 'd1,
        FP16    = 'd2,
        FP8     = 'd3,
        FP16ALT = 'd4,
        FP8ALT  = 'd5
    } fp_format_e;

    // Width of the scoreboard check/error counters.
    localparam int unsigned SB_CNT_WIDTH = 32;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 8;
            FP16:    return 5;
            FP8:     return 5;
            FP16ALT: return 8;
            FP8ALT:  return 4;
            default: return 11;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 23;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            FP8ALT:  return 3;
            default: return 52;
        endcase
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

endpackage

// File: rtl/fpu_lane_cmp.sv
// Per-lane equality of two FPU results in a given destination format, optionally
// treating any two NaN lanes as equal. Assumes WIDTH is a multiple of 16 and >= 32.
module fpu_lane_cmp
    import fpnew_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter bit          NAN_TOLERANT = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  fp_format_e       fmt,
    output logic             equal
);

    localparam int unsigned N16 = WIDTH / 16;
    localparam int unsigned N8  = WIDTH / 8;
    localparam logic [WIDTH-1:0] Low32Mask = WIDTH'(32'hffff_ffff);

    function automatic logic is_nan(logic [31:0] v, int unsigned e, int unsigned m);
        logic [31:0] man_mask;
        logic [31:0] exp_mask;
        man_mask = (32'd1 << m) - 32'd1;
        exp_mask = ((32'd1 << e) - 32'd1) << m;
        return ((v & exp_mask) == exp_mask) && ((v & man_mask) != '0);
    endfunction

    function automatic logic lane_pass(logic [31:0] x, logic [31:0] y,
                                       int unsigned e, int unsigned m);
        return (x == y) || (NAN_TOLERANT && is_nan(x, e, m) && is_nan(y, e, m));
    endfunction

    logic           ok32;
    logic [N16-1:0] ok16;
    logic [N16-1:0] ok16alt;
    logic [N8-1:0]  ok8;
    logic [N8-1:0]  ok8alt;

    // FP32 uses the low lane; any bits above it must match exactly.
    assign ok32 = lane_pass(a[31:0], b[31:0], exp_bits(FP32), man_bits(FP32)) &&
                  (((a ^ b) & ~Low32Mask) == '0);

    for (genvar i = 0; i < N16; i++) begin : g_lane16
        assign ok16[i]    = lane_pass(32'(a[16*i +: 16]), 32'(b[16*i +: 16]),
                                      exp_bits(FP16), man_bits(FP16));
        assign ok16alt[i] = lane_pass(32'(a[16*i +: 16]), 32'(b[16*i +: 16]),
                                      exp_bits(FP16ALT), man_bits(FP16ALT));
    end

    for (genvar i = 0; i < N8; i++) begin : g_lane8
        assign ok8[i]    = lane_pass(32'(a[8*i +: 8]), 32'(b[8*i +: 8]),
                                     exp_bits(FP8), man_bits(FP8));
        assign ok8alt[i] = lane_pass(32'(a[8*i +: 8]), 32'(b[8*i +: 8]),
                                     exp_bits(FP8ALT), man_bits(FP8ALT));
    end

    always_comb begin
        equal = (a == b);
        if (fp_width(fmt) <= WIDTH) begin
            case (fmt)
                FP32:    equal = ok32;
                FP16:    equal = &ok16;
                FP16ALT: equal = &ok16alt;
                FP8:     equal = &ok8;
                FP8ALT:  equal = &ok8alt;
                default: equal = (a == b);
            endcase
        end
    end

endmodule

// File: rtl/fpu_result_scoreboard.sv
// In-order scoreboard: expected results queue on FPU accept, compare on FPU result,
// reporting mismatch detail and saturating check/error counters.
module fpu_result_scoreboard
    import fpnew_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 8,
    parameter bit          NAN_TOLERANT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_exp_i,
    input  fp_format_e              push_fmt_i,
    input  logic                    pop_i,
    input  logic [WIDTH-1:0]        result_i,
    output logic                    mismatch_o,
    output logic [WIDTH-1:0]        mism_exp_o,
    output logic [WIDTH-1:0]        mism_got_o,
    output logic [SB_CNT_WIDTH-1:0] chk_cnt_o,
    output logic [SB_CNT_WIDTH-1:0] err_cnt_o,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = SB_CNT_WIDTH;

    logic [WIDTH-1:0] mem_exp_q [DEPTH];
    fp_format_e       mem_fmt_q [DEPTH];

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             mismatch_q, mismatch_d;
    logic [WIDTH-1:0] mism_exp_q, mism_exp_d;
    logic [WIDTH-1:0] mism_got_q, mism_got_d;
    logic [CntW-1:0]  chk_cnt_q, chk_cnt_d;
    logic [CntW-1:0]  err_cnt_q, err_cnt_d;

    logic             do_push;
    logic             do_pop;
    logic             mem_we;
    logic             lanes_equal;
    logic [WIDTH-1:0] head_exp;
    fp_format_e       head_fmt;

    assign head_exp = mem_exp_q[rd_ptr_q];
    assign head_fmt = mem_fmt_q[rd_ptr_q];

    fpu_lane_cmp #(
        .WIDTH        (WIDTH),
        .NAN_TOLERANT (NAN_TOLERANT)
    ) u_lane_cmp (
        .a     (head_exp),
        .b     (result_i),
        .fmt   (head_fmt),
        .equal (lanes_equal)
    );

    always_comb begin
        do_pop      = pop_i && !empty_q;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        do_push     = push_i && (!full_q || do_pop);
        mem_we      = do_push && !clear_i;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mismatch_d  = 1'b0;
        mism_exp_d  = mism_exp_q;
        mism_got_d  = mism_got_q;
        chk_cnt_d   = chk_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (clear_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            mism_exp_d  = '0;
            mism_got_d  = '0;
            chk_cnt_d   = '0;
            err_cnt_d   = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop) begin
                level_d = level_q + LvlW'(1);
            end else if (!do_push && do_pop) begin
                level_d = level_q - LvlW'(1);
            end
            if (push_i && full_q && !pop_i) overflow_d = 1'b1;
            if (pop_i && empty_q) underflow_d = 1'b1;
            if (do_pop) begin
                if (chk_cnt_q != '1) chk_cnt_d = chk_cnt_q + CntW'(1);
                if (!lanes_equal) begin
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CntW'(1);
                    mismatch_d = 1'b1;
                    mism_exp_d = head_exp;
                    mism_got_d = result_i;
                end
            end
        end
        full_d  = (level_d == LvlW'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_exp_q[wr_ptr_q] <= push_exp_i;
            mem_fmt_q[wr_ptr_q] <= push_fmt_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            mismatch_q  <= 1'b0;
            mism_exp_q  <= '0;
            mism_got_q  <= '0;
            chk_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            mismatch_q  <= mismatch_d;
            mism_exp_q  <= mism_exp_d;
            mism_got_q  <= mism_got_d;
            chk_cnt_q   <= chk_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign level_o     = level_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign mismatch_o  = mismatch_q;
    assign mism_exp_o  = mism_exp_q;
    assign mism_got_o  = mism_got_q;
    assign chk_cnt_o   = chk_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_fpu_result_scoreboard.sv
// Directed and random checks of the result scoreboard against a queue-based model,
// with a NaN-tolerant and a bit-exact instance driven by the same stimulus.
module tb_fpu_result_scoreboard;
    import fpnew_pkg::*;

    localparam int unsigned W = 32;
    localparam int unsigned D = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        push = 1'b0;
    logic [W-1:0] pexp = '0;
    fp_format_e  pfmt = FP32;
    logic        pop = 1'b0;
    logic [W-1:0] res = '0;

    logic        mism [2];
    logic [W-1:0] mexp [2];
    logic [W-1:0] mgot [2];
    logic [31:0] chk [2];
    logic [31:0] err [2];
    logic [3:0]  lvl [2];
    logic        full [2];
    logic        empty [2];
    logic        ovf [2];
    logic        unf [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        fpu_result_scoreboard #(
            .WIDTH        (W),
            .DEPTH        (D),
            .NAN_TOLERANT (k == 0)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .clear_i     (clear),
            .push_i      (push),
            .push_exp_i  (pexp),
            .push_fmt_i  (pfmt),
            .pop_i       (pop),
            .result_i    (res),
            .mismatch_o  (mism[k]),
            .mism_exp_o  (mexp[k]),
            .mism_got_o  (mgot[k]),
            .chk_cnt_o   (chk[k]),
            .err_cnt_o   (err[k]),
            .level_o     (lvl[k]),
            .full_o      (full[k]),
            .empty_o     (empty[k]),
            .overflow_o  (ovf[k]),
            .underflow_o (unf[k])
        );
    end

    // Reference model: one queue of pending expectations, per-instance compare results.
    logic [31:0] m_qe[$];
    fp_format_e  m_qf[$];
    logic [31:0] m_chk;
    bit          m_ovf, m_unf;
    logic [31:0] m_err [2];
    bit          m_mism [2];
    logic [31:0] m_mexp [2];
    logic [31:0] m_mgot [2];

    typedef struct { int lw; int e; int m; } geom_t;

    function automatic geom_t geom(fp_format_e f);
        geom_t g;
        case (f)
            FP32:    g = '{32, 8, 23};
            FP16:    g = '{16, 5, 10};
            FP16ALT: g = '{16, 8, 7};
            FP8:     g = '{8, 5, 2};
            FP8ALT:  g = '{8, 4, 3};
            default: g = '{0, 0, 0};
        endcase
        return g;
    endfunction

    function automatic bit lane_is_nan(longint unsigned lane, geom_t g);
        longint unsigned ex, mn;
        ex = (lane >> g.m) % (64'd1 << g.e);
        mn = lane % (64'd1 << g.m);
        return (ex == (64'd1 << g.e) - 1) && (mn != 0);
    endfunction

    function automatic bit model_equal(logic [31:0] x, logic [31:0] y, fp_format_e f, bit tol);
        geom_t g;
        longint unsigned lx, ly;
        g = geom(f);
        if (g.lw == 0) return x == y;
        for (int i = 0; i < 32 / g.lw; i++) begin
            lx = (longint'(x) >> (i * g.lw)) % (64'd1 << g.lw);
            ly = (longint'(y) >> (i * g.lw)) % (64'd1 << g.lw);
            if (lx != ly && !(tol && lane_is_nan(lx, g) && lane_is_nan(ly, g))) return 0;
        end
        return 1;
    endfunction

    function automatic logic [31:0] mk_nan(fp_format_e f);
        geom_t g;
        longint unsigned v, lane;
        g = geom(f);
        if (g.lw == 0) return $urandom;
        v = 0;
        for (int i = 0; i < 32 / g.lw; i++) begin
            lane = ((64'd1 << g.e) - 1) << g.m;
            lane = lane | (longint'($urandom) % (64'd1 << g.m)) | 64'd1;
            lane = lane | (longint'($urandom_range(0, 1)) << (g.e + g.m));
            v = v | (lane << (i * g.lw));
        end
        return v[31:0];
    endfunction

    task automatic model_reset();
        m_qe.delete();
        m_qf.delete();
        m_chk = 0;
        m_ovf = 0;
        m_unf = 0;
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 0; m_mism[k] = 0; m_mexp[k] = 0; m_mgot[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit was_full, popped;
        logic [31:0] he;
        fp_format_e hf;
        if (clear) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) m_mism[k] = 0;
        was_full = (m_qe.size() == D);
        popped = 0;
        if (pop) begin
            if (m_qe.size() == 0) begin
                m_unf = 1;
            end else begin
                he = m_qe.pop_front();
                hf = m_qf.pop_front();
                popped = 1;
                if (m_chk != 32'hffff_ffff) m_chk++;
                for (int k = 0; k < 2; k++) begin
                    if (!model_equal(he, res, hf, k == 0)) begin
                        if (m_err[k] != 32'hffff_ffff) m_err[k]++;
                        m_mism[k] = 1;
                        m_mexp[k] = he;
                        m_mgot[k] = res;
                    end
                end
            end
        end
        if (push) begin
            if (!was_full || popped) begin
                m_qe.push_back(pexp);
                m_qf.push_back(pfmt);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            string t;
            t = $sformatf("%s.%0d", tag, k);
            check({t, ".level"}, 64'(lvl[k]), 64'(m_qe.size()));
            check({t, ".full"}, 64'(full[k]), 64'(m_qe.size() == D));
            check({t, ".empty"}, 64'(empty[k]), 64'(m_qe.size() == 0));
            check({t, ".ovf"}, 64'(ovf[k]), 64'(m_ovf));
            check({t, ".unf"}, 64'(unf[k]), 64'(m_unf));
            check({t, ".chk"}, 64'(chk[k]), 64'(m_chk));
            check({t, ".err"}, 64'(err[k]), 64'(m_err[k]));
            check({t, ".mism"}, 64'(mism[k]), 64'(m_mism[k]));
            check({t, ".mexp"}, 64'(mexp[k]), 64'(m_mexp[k]));
            check({t, ".mgot"}, 64'(mgot[k]), 64'(m_mgot[k]));
        end
    endtask

    task automatic do_push(input fp_format_e f, input logic [31:0] v);
        push = 1; pfmt = f; pexp = v;
        tick();
        push = 0;
    endtask

    task automatic do_pop(input logic [31:0] v);
        pop = 1; res = v;
        tick();
        pop = 0;
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_all("reset");

        // Exact FP32 match, popped two cycles after the push.
        do_push(FP32, 32'h3f80_0000);
        tick();
        do_pop(32'h3f80_0000);
        check_all("fp32_match");
        check("fp32_match.chk", 64'(chk[0]), 64'd1);
        check("fp32_match.mism", 64'(mism[0]), 64'd0);

        // FP8 single-lane mismatch: pulse for exactly one cycle, detail held.
        do_push(FP8, 32'h6aed_7c56);
        do_pop(32'h6aed_7c57);
        check_all("fp8_miss");
        check("fp8_miss.pulse", 64'(mism[0]), 64'd1);
        check("fp8_miss.err", 64'(err[0]), 64'd1);
        check("fp8_miss.mexp", 64'(mexp[0]), 64'h6aed_7c56);
        check("fp8_miss.mgot", 64'(mgot[0]), 64'h6aed_7c57);
        tick();
        check("fp8_miss.pulse_end", 64'(mism[0]), 64'd0);
        check("fp8_miss.hold", 64'(mgot[0]), 64'h6aed_7c57);

        // Different NaN payloads: equal when tolerant, mismatch when bit-exact.
        do_push(FP32, 32'h7fc0_0000);
        do_pop(32'h7f80_0001);
        check_all("nan_eq");
        check("nan_eq.tol_err", 64'(err[0]), 64'd1);
        check("nan_eq.exact_err", 64'(err[1]), 64'd2);
        check("nan_eq.exact_mism", 64'(mism[1]), 64'd1);

        // Infinity is not a NaN.
        do_push(FP16ALT, 32'h7f80_7f80);
        do_pop(32'h7f81_7f80);
        check_all("al16_inf");
        check("al16_inf.mism", 64'(mism[0]), 64'd1);
        check("al16_inf.err", 64'(err[0]), 64'd2);

        do_clear();
        check_all("clear");
        check("clear.chk", 64'(chk[0]), 64'd0);
        check("clear.empty", 64'(empty[0]), 64'd1);

        // Fill to DEPTH, drop the extra push, then push+pop while full.
        for (int i = 0; i < 8; i++) do_push(FP32, 32'h4000_0000 + i);
        check_all("fill8");
        check("fill8.full", 64'(full[0]), 64'd1);
        check("fill8.ovf", 64'(ovf[0]), 64'd0);
        do_push(FP32, 32'hdead_beef);
        check_all("push9");
        check("push9.ovf", 64'(ovf[0]), 64'd1);
        check("push9.level", 64'(lvl[0]), 64'd8);
        push = 1; pfmt = FP16; pexp = 32'h1234_5678;
        do_pop(m_qe[0]);
        push = 0;
        check_all("full_pushpop");
        check("full_pushpop.level", 64'(lvl[0]), 64'd8);
        for (int i = 0; i < 8; i++) begin
            do_pop(m_qe[0]);
            check_all("drain");
        end
        check("drain.empty", 64'(empty[0]), 64'd1);
        check("drain.err", 64'(err[0]), 64'd0);

        do_clear();
        // Pop on empty with a simultaneous push.
        push = 1; pfmt = FP32; pexp = 32'h3f00_0000;
        do_pop(32'h0);
        push = 0;
        check_all("underflow");
        check("underflow.unf", 64'(unf[0]), 64'd1);
        check("underflow.chk", 64'(chk[0]), 64'd0);
        check("underflow.level", 64'(lvl[0]), 64'd1);

        // Asynchronous reset with entries pending.
        do_clear();
        for (int i = 0; i < 4; i++) do_push(FP16, 32'h3c00_3c00 + i);
        do_pop(m_qe[0]);
        check("prereset.level", 64'(lvl[0]), 64'd3);
        check("prereset.chk", 64'(chk[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.level", 64'(lvl[0]), 64'd0);
        check("async_rst.empty", 64'(empty[0]), 64'd1);
        #3 rst_n = 1'b1;
        repeat (3) begin
            tick();
            check_all("post_rst");
        end
        check("post_rst.mism", 64'(mism[0]), 64'd0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int phase;
            phase = (n / 50) % 3;
            clear = ($urandom_range(0, 99) == 0);
            push = (phase == 0) ? ($urandom_range(0, 3) != 0) :
                   (phase == 1) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1);
            pfmt = fp_format_e'($urandom_range(0, 5));
            pexp = ($urandom_range(0, 3) == 0) ? mk_nan(pfmt) : $urandom;
            pop = (phase == 0) ? ($urandom_range(0, 3) == 0) :
                  (phase == 1) ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1);
            res = $urandom;
            if (pop && m_qe.size() > 0) begin
                case ($urandom_range(0, 3))
                    0: res = m_qe[0];
                    1: res = m_qe[0] ^ (32'd1 << $urandom_range(0, 31));
                    2: res = mk_nan(m_qf[0]);
                    default: res = $urandom;
                endcase
            end
            tick();
            check_all("rand");
        end
        clear = 0; push = 0; pop = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
